// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI encodings for the instruction-fetch AXI read bridge.
package inst_axi_bridge_pkg;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_axi_bridge.sv
// Converts the IF-stage SRAM-like fetch interface into single-beat AXI reads,
// with one AR holding register and a bounded count of outstanding reads.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter logic [3:0]  ARID      = 4'h0,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        resp_err
);

    localparam logic [1:0] CNT_MAX = 2'(MAX_OUTST);

    logic        ar_busy;
    logic [31:0] ar_addr;
    logic [1:0]  cnt;
    logic        addr_ok;
    logic        data_ok;
    logic        ar_hs;

    // Handshake outputs are forced low while reset is held, so nothing leaks
    // out during the cycle in which the synchronous reset takes effect.
    assign addr_ok = !reset && inst_sram_req && !ar_busy && (cnt < CNT_MAX);
    assign rready  = !reset && (cnt != 2'd0);
    assign data_ok = rvalid && rready;
    assign ar_hs   = arvalid && arready;

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok;
    assign inst_sram_rdata   = rdata;
    assign resp_err          = data_ok && (rresp != RESP_OKAY);

    assign arvalid = ar_busy && !reset;
    assign araddr  = ar_addr;
    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_busy <= 1'b0;
            ar_addr <= 32'd0;
        end else if (addr_ok) begin
            ar_busy <= 1'b1;
            ar_addr <= inst_sram_addr;
        end else if (ar_hs) begin
            ar_busy <= 1'b0;
        end
    end

    // Accept and return in the same cycle leave the count untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 2'd0;
        end else begin
            case ({addr_ok, data_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    rid_match: assert property (@(posedge clk) disable iff (reset)
        data_ok |-> (rid == ARID));

    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                             inst_sram_wdata, rlast, rid};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: behavioural model + AXI slave queue, directed and random phases.
module tb_inst_axi_bridge;

    localparam int MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, resp_err;

    inst_axi_bridge #(.ARID(4'h0), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what the bridge must hold, per the accept/return rules.
    bit          m_busy;
    logic [31:0] m_addr;
    int          m_cnt;
    logic [31:0] req_q[$];
    logic [31:0] slave_q[$];
    int          n_addr_ok, n_data_ok, n_ar_hs;
    logic        e_addr_ok, e_rready, e_data_ok;
    logic [31:0] exp_word;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1e80_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_addr_ok", 32'(inst_sram_addr_ok), 0);
            chk("rst_data_ok", 32'(inst_sram_data_ok), 0);
            chk("rst_arvalid", 32'(arvalid), 0);
            chk("rst_rready", 32'(rready), 0);
            chk("rst_resp_err", 32'(resp_err), 0);
            m_busy = 0; m_addr = 0; m_cnt = 0;
            req_q.delete(); slave_q.delete();
        end else begin
            e_addr_ok = inst_sram_req && !m_busy && (m_cnt < MAX_OUTST);
            e_rready  = (m_cnt != 0);
            e_data_ok = rvalid && e_rready;
            chk("addr_ok", 32'(inst_sram_addr_ok), 32'(e_addr_ok));
            chk("rready", 32'(rready), 32'(e_rready));
            chk("data_ok", 32'(inst_sram_data_ok), 32'(e_data_ok));
            chk("arvalid", 32'(arvalid), 32'(m_busy));
            chk("resp_err", 32'(resp_err), 32'(e_data_ok && rresp != 2'b00));
            chk("rdata_pass", inst_sram_rdata, rdata);
            chk("ar_payload", 32'({arid, arlen, arsize, arburst, arlock, arcache, arprot}),
                32'({4'h0, 8'h00, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000}));
            if (m_busy) chk("araddr", araddr, m_addr);
            if (e_data_ok) begin
                n_data_ok++;
                if (req_q.size() == 0) chk("order_underflow", 32'(req_q.size()), 1);
                else begin
                    exp_word = mem(req_q.pop_front());
                    chk("order_rdata", inst_sram_rdata, exp_word);
                end
                if (slave_q.size() != 0) void'(slave_q.pop_front());
            end
            if (m_busy && arready) begin
                slave_q.push_back(m_addr);
                m_busy = 0;
                n_ar_hs++;
            end
            if (e_addr_ok) begin
                m_busy = 1;
                m_addr = inst_sram_addr;
                req_q.push_back(inst_sram_addr);
                n_addr_ok++;
            end
            m_cnt = m_cnt + int'(e_addr_ok) - int'(e_data_ok);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        inst_sram_req = 0; arready = 1; rresp = 2'b00;
        while ((m_cnt != 0 || m_busy) && n < 60) begin
            rvalid = (slave_q.size() > 0);
            rdata  = rvalid ? mem(slave_q[0]) : 32'd0;
            cyc();
            n++;
        end
        rvalid = 0;
        if (n >= 60) chk("drain_timeout", 32'(m_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, acc;
        logic tick;
        logic [31:0] a;

        reset = 1; inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
        arready = 0; rid = 4'h0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        cyc(); cyc(); cyc();
        reset = 0;
        cyc();

        // Single fetch
        d0 = n_data_ok;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; arready = 1;
        @(negedge clk); chk("t1_addr_ok", 32'(inst_sram_addr_ok), 1);
        cyc(); inst_sram_req = 0;
        @(negedge clk); chk("t1_arvalid", 32'(arvalid), 1); chk("t1_araddr", araddr, 32'h1c00_0000);
        cyc(); cyc();
        rvalid = 1; rdata = 32'h0280_0000;
        @(negedge clk); chk("t1_data_ok", 32'(inst_sram_data_ok), 1);
        chk("t1_rdata", inst_sram_rdata, 32'h0280_0000);
        cyc(); rvalid = 0; cyc(); cyc();
        chk("t1_once", 32'(n_data_ok - d0), 1);

        // AR backpressure
        arready = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010;
        @(negedge clk); chk("t2_accept", 32'(inst_sram_addr_ok), 1);
        cyc(); inst_sram_addr = 32'h1c00_0014;
        h0 = n_ar_hs;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_arvalid", 32'(arvalid), 1);
            chk("t2_araddr", araddr, 32'h1c00_0010);
            chk("t2_no_accept", 32'(inst_sram_addr_ok), 0);
            cyc();
        end
        arready = 1;
        cyc(); inst_sram_req = 0;
        cyc();
        chk("t2_one_hs", 32'(n_ar_hs - h0), 1);
        drain();

        // Outstanding limit
        a = 32'h1c00_0000; inst_sram_addr = a; inst_sram_req = 1; arready = 1; rvalid = 0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tick = inst_sram_addr_ok;
            if (tick) acc++;
            cyc();
            if (tick) begin a = a + 4; inst_sram_addr = a; end
        end
        chk("t3_limit_two", 32'(acc), 2);
        rvalid = 1; rdata = mem(slave_q[0]);
        @(negedge clk); chk("t3_ret", 32'(inst_sram_data_ok), 1); chk("t3_full", 32'(inst_sram_addr_ok), 0);
        cyc(); rvalid = 0;
        @(negedge clk); chk("t3_refill", 32'(inst_sram_addr_ok), 1);
        cyc(); inst_sram_req = 0;
        drain();

        // Simultaneous accept and return with one outstanding
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100; arready = 1;
        cyc(); inst_sram_req = 0; cyc();
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0104;
        rvalid = 1; rdata = mem(slave_q[0]);
        @(negedge clk); chk("t4_both_addr", 32'(inst_sram_addr_ok), 1); chk("t4_both_data", 32'(inst_sram_data_ok), 1);
        cyc(); rvalid = 0; inst_sram_addr = 32'h1c00_0108;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) acc++;
            cyc();
            inst_sram_addr = inst_sram_addr + 4;
        end
        chk("t4_one_more", 32'(acc), 1);
        inst_sram_req = 0;
        drain();

        // Error response
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0200; arready = 1;
        cyc(); inst_sram_req = 0; cyc();
        rvalid = 1; rdata = mem(32'h1c00_0200); rresp = 2'b10;
        @(negedge clk); chk("t5_data_ok", 32'(inst_sram_data_ok), 1); chk("t5_resp_err", 32'(resp_err), 1);
        chk("t5_rdata", inst_sram_rdata, 32'h0280_0200);
        cyc(); rvalid = 0; rresp = 2'b00;
        @(negedge clk); chk("t5_err_pulse", 32'(resp_err), 0); chk("t5_cnt_zero", 32'(rready), 0);
        cyc();

        // Reset with an AR pending and two outstanding
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0300; arready = 1;
        cyc();
        cyc(); arready = 0;
        cyc(); inst_sram_req = 0;
        @(negedge clk); chk("t6_pre_arvalid", 32'(arvalid), 1); chk("t6_pre_rready", 32'(rready), 1);
        cyc(); reset = 1;
        @(negedge clk); chk("t6_rst_arvalid", 32'(arvalid), 0);
        cyc(); reset = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0400; arready = 1;
        @(negedge clk); chk("t6_arvalid", 32'(arvalid), 0); chk("t6_rready", 32'(rready), 0);
        chk("t6_fresh", 32'(inst_sram_addr_ok), 1);
        cyc(); inst_sram_req = 0;
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 599) == 0);
            inst_sram_req   = 1'($urandom_range(0, 1));
            inst_sram_addr  = $urandom & 32'hffff_fffc;
            inst_sram_wr    = 1'($urandom_range(0, 1));
            inst_sram_wstrb = 4'($urandom);
            inst_sram_wdata = $urandom;
            inst_sram_size  = 2'($urandom);
            arready         = ($urandom_range(0, 3) != 0);
            rlast           = 1'($urandom_range(0, 1));
            rvalid          = (slave_q.size() > 0) && ($urandom_range(0, 2) != 0);
            rdata           = rvalid ? mem(slave_q[0]) : $urandom;
            rresp           = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
            cyc();
        end
        reset = 0;
        drain();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
